// File: rtl/ddr_pkg.sv
// Shared HDR-DDR word layout constants and FSM encoding, used by both the
// receive deserializer and the transmit serializer.
package ddr_pkg;

   localparam int unsigned DDR_WORD_BITS = 20;

   localparam int unsigned IDX_PRE_LAST  = 1;
   localparam int unsigned IDX_DATA_LAST = 17;
   localparam int unsigned IDX_P1        = 18;
   localparam int unsigned IDX_P0        = 19;

   localparam logic [1:0] PRE_CMD  = 2'b01;
   localparam logic [1:0] PRE_DATA = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_ERR_HOLD
   } ddr_state_e;

endpackage

// File: rtl/ddr_parity_calc.sv
// Expected HDR-DDR parity pair {P1,P0} for a 16-bit data field.
module ddr_parity_calc (
   input  logic [15:0] data,
   output logic [1:0]  parity
);

   // P1 covers odd data bits; P0 covers even bits and is inverted.
   always_comb begin
      parity[1] = ^(data & 16'hAAAA);
      parity[0] = ~^(data & 16'h5555);
   end

endmodule

// File: rtl/ddr_rx_deserializer.sv
// HDR-DDR receive deserializer: samples SDA on SCL edges, assembles 20-bit
// words, checks parity and pulses o_word_valid once per completed word.
module ddr_rx_deserializer
   import ddr_pkg::*;
#(
   parameter int unsigned WORD_BITS = DDR_WORD_BITS,
   parameter int unsigned WCNT_W    = 8
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_n,
   input  logic              i_deser_en,
   input  logic              i_err_mode,
   input  logic              i_scl_pos_edge,
   input  logic              i_scl_neg_edge,
   input  logic              i_sda,
   input  logic [5:0]        i_bit_count,
   output logic [1:0]        o_preamble,
   output logic [15:0]       o_data_word,
   output logic              o_word_valid,
   output logic              o_parity_err,
   output logic              o_sync_err,
   output logic [WCNT_W-1:0] o_word_cnt
);

   ddr_state_e           state;
   logic [WORD_BITS-1:0] shreg;
   logic [5:0]           idx;
   logic                 bad;

   logic                 sample;
   logic                 mismatch;
   logic                 last;
   logic [5:0]           next_idx;
   logic [WORD_BITS-1:0] wr_mask;
   logic [WORD_BITS-1:0] rx_word;
   logic [1:0]           rx_pre;
   logic [15:0]          rx_data;
   logic [1:0]           rx_par;
   logic [1:0]           exp_par;

   always_comb begin
      sample   = i_deser_en & ~i_err_mode & (i_scl_pos_edge | i_scl_neg_edge);
      mismatch = (i_bit_count != idx);
      last     = (i_bit_count == 6'(IDX_P0));
      // After a mismatch the index resyncs to i_bit_count+1; when aligned
      // that is the same value, so one expression covers both cases.
      next_idx = (i_bit_count >= 6'(WORD_BITS - 1)) ? '0 : i_bit_count + 6'd1;
      wr_mask  = (i_bit_count < 6'(WORD_BITS)) ? (WORD_BITS'(1) << i_bit_count) : '0;
      // P0 arrives on the completing edge, so take it straight from SDA.
      rx_word         = shreg;
      rx_word[IDX_P0] = i_sda;
      rx_pre          = {rx_word[0], rx_word[IDX_PRE_LAST]};
      rx_data         = {<<{rx_word[IDX_DATA_LAST:IDX_PRE_LAST+1]}};
      rx_par          = {rx_word[IDX_P1], rx_word[IDX_P0]};
   end

   ddr_parity_calc u_parity (
      .data   (rx_data),
      .parity (exp_par)
   );

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         idx          <= '0;
         bad          <= 1'b0;
         o_preamble   <= '0;
         o_data_word  <= '0;
         o_word_valid <= 1'b0;
         o_parity_err <= 1'b0;
         o_sync_err   <= 1'b0;
         o_word_cnt   <= '0;
      end else begin
         o_word_valid <= 1'b0;
         o_parity_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               shreg      <= '0;
               idx        <= '0;
               bad        <= 1'b0;
               o_sync_err <= 1'b0;
               o_word_cnt <= '0;
               if (i_deser_en) state <= ST_RUN;
            end
            ST_RUN: begin
               if (!i_deser_en) begin
                  state <= ST_IDLE;
                  shreg <= '0;
                  idx   <= '0;
                  bad   <= 1'b0;
               end else if (i_err_mode) begin
                  state <= ST_ERR_HOLD;
                  shreg <= '0;
                  idx   <= '0;
                  bad   <= 1'b0;
               end else if (sample) begin
                  shreg <= (shreg & ~wr_mask) | (wr_mask & {WORD_BITS{i_sda}});
                  idx   <= next_idx;
                  if (mismatch) begin
                     o_sync_err <= 1'b1;
                     bad        <= 1'b1;
                  end
                  if (last) begin
                     bad <= 1'b0;
                     if (!bad && !mismatch) begin
                        o_word_valid <= 1'b1;
                        o_preamble   <= rx_pre;
                        o_data_word  <= rx_data;
                        o_parity_err <= (rx_par != exp_par);
                        if (o_word_cnt != '1) o_word_cnt <= o_word_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_ERR_HOLD: begin
               shreg <= '0;
               idx   <= '0;
               bad   <= 1'b0;
               if (!i_deser_en)      state <= ST_IDLE;
               else if (!i_err_mode) state <= ST_RUN;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Randomized bench for ddr_rx_deserializer against a word-level reference
// model: every completed word is predicted and matched to a valid pulse.
module tb_ddr_rx_deserializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        err_mode;
   logic        scl_pos;
   logic        scl_neg;
   logic        sda;
   logic [5:0]  bit_count;
   logic [1:0]  preamble;
   logic [15:0] data_word;
   logic        word_valid;
   logic        parity_err;
   logic        sync_err;
   logic [7:0]  word_cnt;

   always #5 clk = ~clk;

   ddr_rx_deserializer #(.WORD_BITS(20), .WCNT_W(8)) dut (
      .i_sys_clk      (clk),
      .i_rst_n        (rst_n),
      .i_deser_en     (en),
      .i_err_mode     (err_mode),
      .i_scl_pos_edge (scl_pos),
      .i_scl_neg_edge (scl_neg),
      .i_sda          (sda),
      .i_bit_count    (bit_count),
      .o_preamble     (preamble),
      .o_data_word    (data_word),
      .o_word_valid   (word_valid),
      .o_parity_err   (parity_err),
      .o_sync_err     (sync_err),
      .o_word_cnt     (word_cnt)
   );

   typedef struct {
      logic [1:0]  pre;
      logic [15:0] data;
      logic        perr;
      logic [7:0]  cnt;
      logic        sync;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned exp_cnt = 0;
   logic        exp_sync = 1'b0;
   logic        edge_phase = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Parity from the rules: P1 = odd count of set odd bits, P0 = even count of set even bits.
   function automatic logic [1:0] ref_parity(input logic [15:0] d);
      int unsigned odd_ones = 0;
      int unsigned even_ones = 0;
      for (int b = 0; b < 16; b++)
         if (d[b]) begin
            if (b % 2 == 1) odd_ones++;
            else            even_ones++;
         end
      return {logic'(odd_ones % 2 == 1), logic'(even_ones % 2 == 0)};
   endfunction

   // Bit k of the serial word, in transmission order.
   function automatic logic word_bit(input logic [1:0] pre, input logic [15:0] d,
                                     input logic [1:0] par, input int unsigned k);
      if (k < 2)       return pre[1 - k];
      else if (k < 18) return d[17 - k];
      else             return par[19 - k];
   endfunction

   task automatic drive_edge(input logic b, input logic [5:0] k, input int unsigned gap);
      repeat (gap) @(negedge clk);
      sda       = b;
      bit_count = k;
      if ($urandom_range(7) == 0) begin
         scl_pos = 1'b1;
         scl_neg = 1'b1;
      end else begin
         scl_pos = ~edge_phase;
         scl_neg = edge_phase;
      end
      edge_phase = ~edge_phase;
      @(negedge clk);
      scl_pos = 1'b0;
      scl_neg = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] pre, input logic [15:0] d, input logic [1:0] par);
      exp_t e;
      if (exp_cnt < 255) exp_cnt++;
      e.pre  = pre;
      e.data = d;
      e.perr = (par != ref_parity(d));
      e.cnt  = 8'(exp_cnt);
      e.sync = exp_sync;
      exp_q.push_back(e);
   endtask

   // Sends bits first..last of a word; a word that reaches bit 19 is expected.
   task automatic send_bits(input logic [1:0] pre, input logic [15:0] d, input logic [1:0] par,
                            input int unsigned first, input int unsigned last,
                            input int unsigned max_gap);
      for (int unsigned k = first; k <= last; k++) begin
         if (k == 19) push_exp(pre, d, par);
         drive_edge(word_bit(pre, d, par, k), 6'(k), $urandom_range(max_gap));
      end
   endtask

   task automatic send_word(input logic [1:0] pre, input logic [15:0] d, input logic [1:0] par,
                            input int unsigned max_gap);
      send_bits(pre, d, par, 0, 19, max_gap);
   endtask

   task automatic set_enable(input logic v);
      @(negedge clk);
      en = v;
      if (!v) begin
         exp_cnt  = 0;
         exp_sync = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_pre"},   32'(preamble), 0);
      check_eq({tag, "_data"},  32'(data_word), 0);
      check_eq({tag, "_valid"}, 32'(word_valid), 0);
      check_eq({tag, "_perr"},  32'(parity_err), 0);
      check_eq({tag, "_sync"},  32'(sync_err), 0);
      check_eq({tag, "_cnt"},   32'(word_cnt), 0);
   endtask

   always @(negedge clk) begin
      if (word_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_valid", 32'(word_valid), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("word_pre",  32'(preamble), 32'(e.pre));
            check_eq("word_data", 32'(data_word), 32'(e.data));
            check_eq("word_perr", 32'(parity_err), 32'(e.perr));
            check_eq("word_cnt",  32'(word_cnt), 32'(e.cnt));
            check_eq("word_sync", 32'(sync_err), 32'(e.sync));
         end
      end else begin
         check_eq("perr_idle", 32'(parity_err), 0);
      end
   end

   initial begin
      logic [15:0] d;
      logic [1:0]  pre;
      logic [1:0]  par;

      rst_n = 1'b0; en = 1'b0; err_mode = 1'b0;
      scl_pos = 1'b0; scl_neg = 1'b0; sda = 1'b0; bit_count = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      set_enable(1'b1);

      send_word(2'b10, 16'hA5C3, 2'b01, 0);
      send_word(2'b10, 16'hA5C3, 2'b00, 1);
      send_word(2'b01, 16'h0000, 2'b01, 2);
      repeat (3) @(negedge clk);
      check_eq("directed_cnt", 32'(word_cnt), 3);

      for (int n = 0; n < 40; n++) begin
         d   = 16'($urandom);
         pre = ($urandom_range(2) == 0) ? 2'($urandom) : (($urandom_range(1) == 0) ? 2'b01 : 2'b10);
         par = ref_parity(d);
         if ($urandom_range(3) == 0) par = par ^ 2'($urandom_range(3, 1));
         send_word(pre, d, par, $urandom_range(2));
      end
      repeat (3) @(negedge clk);
      check_eq("random_q_drained", exp_q.size(), 0);

      // Abort mid-word by disabling, then a clean word after re-enable.
      send_bits(2'b10, 16'hFFFF, 2'b11, 0, 9, 1);
      set_enable(1'b0);
      check_eq("disable_cnt", 32'(word_cnt), 0);
      set_enable(1'b1);
      send_word(2'b10, 16'h1234, ref_parity(16'h1234), 1);
      repeat (3) @(negedge clk);
      check_eq("reenable_cnt", 32'(word_cnt), 1);

      // Bit counter skips ahead: index 7 where 5 is due.
      d = 16'h5AA5;
      send_bits(2'b10, d, ref_parity(d), 0, 4, 1);
      drive_edge(1'b1, 6'd7, 1);
      exp_sync = 1'b1;
      for (int unsigned k = 8; k <= 19; k++)
         drive_edge(word_bit(2'b10, d, ref_parity(d), k), 6'(k), 1);
      repeat (3) @(negedge clk);
      check_eq("sync_set", 32'(sync_err), 1);
      check_eq("sync_no_valid_cnt", 32'(word_cnt), 1);
      send_word(2'b01, 16'hBEEF, ref_parity(16'hBEEF), 1);
      repeat (3) @(negedge clk);
      check_eq("sync_sticky", 32'(sync_err), 1);
      check_eq("sync_next_cnt", 32'(word_cnt), 2);

      // Error-recovery count in the middle of a word.
      send_bits(2'b10, 16'hC0DE, 2'b00, 0, 9, 1);
      @(negedge clk);
      err_mode = 1'b1;
      @(negedge clk);
      for (int unsigned k = 0; k < 38; k++) drive_edge(1'($urandom), 6'(k), $urandom_range(1));
      err_mode = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("errmode_cnt", 32'(word_cnt), 2);
      send_word(2'b10, 16'h0F0F, ref_parity(16'h0F0F), 1);
      repeat (3) @(negedge clk);
      check_eq("errmode_after_cnt", 32'(word_cnt), 3);

      // Saturation with back-to-back words.
      set_enable(1'b0);
      set_enable(1'b1);
      for (int n = 0; n < 256; n++) begin
         d = 16'($urandom);
         send_word(PRE_DATA_c(), d, ref_parity(d), 0);
      end
      repeat (3) @(negedge clk);
      check_eq("sat_cnt", 32'(word_cnt), 255);
      check_eq("sat_q_drained", exp_q.size(), 0);

      // Asynchronous reset mid-word.
      send_bits(2'b10, 16'h7777, 2'b11, 0, 9, 0);
      @(negedge clk);
      rst_n = 1'b0;
      exp_cnt  = 0;
      exp_sync = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("post_rst_cnt", 32'(word_cnt), 0);
      send_word(2'b01, 16'h8001, ref_parity(16'h8001), 1);
      repeat (4) @(negedge clk);
      check_eq("post_rst_word_cnt", 32'(word_cnt), 1);
      check_eq("final_q_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic [1:0] PRE_DATA_c();
      return 2'b10;
   endfunction

endmodule
